isqrt_pipe_responder: RTL and testbench

- Pipelined unsigned 32-bit integer square root engine: y = floor(sqrt(x)).
- Sits on the responder side of the isqrt_x_vld/isqrt_x -> isqrt_y_vld/isqrt_y interface, instantiated at top level next to formula FSMs that stream arguments into it.
- Fully pipelined with no backpressure. Accepts one argument per clock and returns results in order, after a fixed latency set by a parameter.

---
 rtl/isqrt_pkg.sv | 28 ++
 rtl/isqrt_iter_step.sv | 32 +++
 rtl/isqrt_pipe_responder.sv | 77 +++++++
 tb/tb_isqrt_pipe_responder.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/isqrt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : isqrt_pkg
// Brief    : Shared widths, stage register record and helpers for the
//            pipelined integer square root engine.
// Revision : 1.0 - initial release
// ============================================================================
package isqrt_pkg;

    localparam int ISQRT_X_W   = 32;
    localparam int ISQRT_Y_W   = 16;
    localparam int ISQRT_REM_W = 18;
    localparam int ISQRT_ITERS = ISQRT_Y_W;

    typedef struct packed {
        logic                   vld;
        logic [ISQRT_REM_W-1:0] rem;
        logic [ISQRT_Y_W-1:0]   root;
        logic [ISQRT_X_W-1:0]   x_rest;
    } isqrt_stage_t;

    // Stage count must split the iterations evenly; guards 0 against divide-by-zero.
    function automatic bit isqrt_stages_legal(input int n);
        return (n >= 1) && (n <= ISQRT_ITERS) && ((ISQRT_ITERS % n) == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/isqrt_iter_step.sv
`default_nettype none
// ============================================================================
// Module   : isqrt_iter_step
// Brief    : One restoring digit-by-digit square root iteration (combinational).
// Revision : 1.0 - initial release
// ============================================================================
module isqrt_iter_step
    import isqrt_pkg::*;
(
    input  logic [ISQRT_REM_W-1:0] rem_in,
    input  logic [ISQRT_Y_W-1:0]   root_in,
    input  logic [1:0]             x_bits,
    output logic [ISQRT_REM_W-1:0] rem_out,
    output logic [ISQRT_Y_W-1:0]   root_out
);

    logic [ISQRT_REM_W+1:0] w_t;
    logic [ISQRT_REM_W+1:0] w_trial;
    logic [ISQRT_REM_W-1:0] w_diff;
    logic                   w_ge;

    assign w_t     = {rem_in, x_bits};
    assign w_trial = {2'b00, root_in, 2'b01};
    assign w_ge    = (w_t >= w_trial);
    // When the trial fits, the true difference is below 2^18, so the low bits suffice.
    assign w_diff  = w_t[ISQRT_REM_W-1:0] - w_trial[ISQRT_REM_W-1:0];

    assign rem_out  = w_ge ? w_diff : w_t[ISQRT_REM_W-1:0];
    assign root_out = {root_in[ISQRT_Y_W-2:0], w_ge};

endmodule
`default_nettype wire

// File: rtl/isqrt_pipe_responder.sv
`default_nettype none
// ============================================================================
// Module   : isqrt_pipe_responder
// Brief    : Fully pipelined 32-bit floor(sqrt(x)), latency n_stages clocks.
// Revision : 1.0 - initial release
// ============================================================================
module isqrt_pipe_responder
    import isqrt_pkg::*;
#(
    parameter int n_stages = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 x_vld,
    input  logic [ISQRT_X_W-1:0] x,
    output logic                 y_vld,
    output logic [ISQRT_Y_W-1:0] y
);

    localparam int c_iters = (n_stages > 0) ? (ISQRT_ITERS / n_stages) : 1;

    generate
        if (!isqrt_stages_legal(n_stages)) begin : g_bad_stages
            $error("isqrt_pipe_responder: n_stages must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    isqrt_stage_t r_stage [0:n_stages-1];

    generate
        for (genvar k = 0; k < n_stages; k++) begin : g_stage
            isqrt_stage_t           w_in;
            logic [ISQRT_REM_W-1:0] w_rem  [0:c_iters];
            logic [ISQRT_Y_W-1:0]   w_root [0:c_iters];
            logic [ISQRT_X_W-1:0]   w_xr   [0:c_iters];

            if (k == 0) begin : g_head
                assign w_in = {x_vld, {ISQRT_REM_W{1'b0}}, {ISQRT_Y_W{1'b0}}, x};
            end else begin : g_link
                assign w_in = r_stage[k-1];
            end

            assign w_rem[0]  = w_in.rem;
            assign w_root[0] = w_in.root;
            assign w_xr[0]   = w_in.x_rest;

            // Radicand is consumed two bits at a time from the MSB end.
            for (genvar j = 0; j < c_iters; j++) begin : g_iter
                isqrt_iter_step u_step (
                    .rem_in   (w_rem[j]),
                    .root_in  (w_root[j]),
                    .x_bits   (w_xr[j][ISQRT_X_W-1:ISQRT_X_W-2]),
                    .rem_out  (w_rem[j+1]),
                    .root_out (w_root[j+1])
                );
                assign w_xr[j+1] = {w_xr[j][ISQRT_X_W-3:0], 2'b00};
            end

            // Only the valid bit is reset; payload may stay unknown until filled.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_stage[k].vld <= 1'b0;
                end else begin
                    r_stage[k].vld <= w_in.vld;
                end
                r_stage[k].rem    <= w_rem[c_iters];
                r_stage[k].root   <= w_root[c_iters];
                r_stage[k].x_rest <= w_xr[c_iters];
            end
        end
    endgenerate

    assign y_vld = r_stage[n_stages-1].vld;
    assign y     = r_stage[n_stages-1].root;

endmodule
`default_nettype wire

// File: tb/tb_isqrt_pipe_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_isqrt_pipe_responder
// Brief    : Self-checking bench; five instances (1..16 stages) share stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_isqrt_pipe_responder;

    localparam int c_ndut = 5;
    localparam int c_ring = 32;

    typedef struct {
        bit          vld;
        logic [31:0] x;
        logic [15:0] exp_y;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        x_vld;
    logic [31:0] x;
    logic [c_ndut-1:0] y_vld_a;
    logic [15:0] y_a [0:c_ndut-1];

    logic [15:0] cur_exp;
    bit          hist_vld [0:c_ring-1];
    logic [15:0] hist_y   [0:c_ring-1];
    int          cyc    = 0;
    bit          chk_en = 1'b0;
    int          checks = 0;
    int          errors = 0;

    bit          soak_in  = 1'b0;
    bit          soak_out = 1'b0;
    int          soak_in_cnt = 0;
    int          soak_out_cnt [0:c_ndut-1];

    vec_t        tbl [0:22];

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < c_ndut; g++) begin : g_dut
            isqrt_pipe_responder #(.n_stages(1 << g)) u_dut (
                .clk   (clk),
                .rst   (rst),
                .x_vld (x_vld),
                .x     (x),
                .y_vld (y_vld_a[g]),
                .y     (y_a[g])
            );
        end
    endgenerate

    function automatic logic [15:0] ref_sqrt(input logic [31:0] v);
        logic [15:0] r;
        logic [15:0] cand;
        logic [63:0] sq;
        r = '0;
        for (int b = 15; b >= 0; b--) begin
            cand = r | (16'd1 << b);
            sq   = {48'd0, cand} * {48'd0, cand};
            if (sq <= {32'd0, v}) r = cand;
        end
        return r;
    endfunction

    // Delay-line expectation: an argument accepted at edge p is due n clocks later.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_ring; i++) hist_vld[i] = 1'b0;
        end
        hist_vld[cyc % c_ring] = x_vld && !rst;
        hist_y[cyc % c_ring]   = cur_exp;
        if (soak_in && x_vld && !rst) soak_in_cnt++;
        cyc++;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < c_ndut; d++) begin
                int ns;
                int idx;
                bit ev;
                ns  = 1 << d;
                idx = 0;
                ev  = 1'b0;
                if (cyc >= ns) begin
                    idx = (cyc - ns) % c_ring;
                    ev  = hist_vld[idx];
                end
                checks++;
                if (y_vld_a[d] !== ev) begin
                    errors++;
                    $display("FAIL y_vld n_stages=%0d cyc=%0d: got %b expected %b", ns, cyc, y_vld_a[d], ev);
                end
                if (ev) begin
                    checks++;
                    if (y_a[d] !== hist_y[idx]) begin
                        errors++;
                        $display("FAIL y n_stages=%0d cyc=%0d: got %h expected %h", ns, cyc, y_a[d], hist_y[idx]);
                    end
                end
                if (soak_out && y_vld_a[d]) soak_out_cnt[d]++;
            end
        end
    end

    task automatic drive(input bit v, input logic [31:0] xv, input logic [15:0] e);
        @(negedge clk);
        x_vld   = v;
        x       = xv;
        cur_exp = e;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 32'd0, 16'd0);
    endtask

    task automatic check_hand(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    initial begin
        tbl[0]  = '{1'b1, 32'd0,          16'd0};
        tbl[1]  = '{1'b1, 32'd1,          16'd1};
        tbl[2]  = '{1'b1, 32'd15,         16'd3};
        tbl[3]  = '{1'b1, 32'hFFFF_FFFF,  16'hFFFF};
        tbl[4]  = '{1'b1, 32'hFFFE_0001,  16'hFFFF};
        tbl[5]  = '{1'b1, 32'd100,        16'd10};
        tbl[6]  = '{1'b0, 32'd0,          16'd0};
        tbl[7]  = '{1'b0, 32'd0,          16'd0};
        tbl[8]  = '{1'b1, 32'd99,         16'd9};
        tbl[9]  = '{1'b1, 32'd81,         16'd9};
        tbl[10] = '{1'b0, 32'd0,          16'd0};
        tbl[11] = '{1'b1, 32'd2,          16'd1};
        tbl[12] = '{1'b1, 32'd3,          16'd1};
        tbl[13] = '{1'b1, 32'd4,          16'd2};
        tbl[14] = '{1'b1, 32'd24,         16'd4};
        tbl[15] = '{1'b1, 32'd25,         16'd5};
        tbl[16] = '{1'b1, 32'h0001_0000,  16'h0100};
        tbl[17] = '{1'b1, 32'hFFFF_FFFE,  16'hFFFF};
        tbl[18] = '{1'b1, 32'hFFFE_0000,  16'hFFFE};
        tbl[19] = '{1'b1, 32'h4000_0000,  16'h8000};
        tbl[20] = '{1'b1, 32'h3FFF_FFFF,  16'h7FFF};
        tbl[21] = '{1'b0, 32'd12345,      16'd0};
        tbl[22] = '{1'b1, 32'd1_000_000,  16'd1000};
        for (int d = 0; d < c_ndut; d++) soak_out_cnt[d] = 0;

        rst = 1'b1; x_vld = 1'b0; x = '0; cur_exp = '0;
        @(posedge clk);
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(2);

        // Single pulse through the 4-stage instance: exactly one hit, 4 clocks on.
        drive(1'b1, 32'd16, 16'd4);
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 32'd0, 16'd0);
            check_hand($sformatf("pulse_vld_%0d", i), {15'd0, y_vld_a[2]}, (i == 3) ? 16'd1 : 16'd0);
            if (i == 3) check_hand("pulse_y", y_a[2], 16'd4);
        end
        idle(4);

        for (int i = 0; i < 23; i++) drive(tbl[i].vld, tbl[i].x, tbl[i].exp_y);
        idle(20);

        // Reset mid-flight: three arguments, reset lands with a dropped fourth.
        drive(1'b1, 32'd36, 16'd6);
        drive(1'b1, 32'd64, 16'd8);
        drive(1'b1, 32'd121, 16'd11);
        @(negedge clk);
        x_vld = 1'b1; x = 32'd144; cur_exp = 16'd12; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; x_vld = 1'b1; x = 32'd49; cur_exp = 16'd7;
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 32'd0, 16'd0);
            check_hand($sformatf("rst_vld_%0d", i), {15'd0, y_vld_a[2]}, (i == 3) ? 16'd1 : 16'd0);
            if (i == 3) check_hand("rst_after_y", y_a[2], 16'd7);
        end
        idle(20);

        soak_out = 1'b1;
        soak_in  = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            logic [31:0] rx;
            bit          rv;
            rx = $urandom;
            if ((i % 97) == 0) rx = 32'hFFFF_FFFF;
            rv = ($urandom_range(0, 99) < 70);
            drive(rv, rx, ref_sqrt(rx));
        end
        @(negedge clk);
        soak_in = 1'b0;
        x_vld = 1'b0;
        idle(20);
        soak_out = 1'b0;
        for (int d = 0; d < c_ndut; d++) begin
            checks++;
            if (soak_out_cnt[d] != soak_in_cnt) begin
                errors++;
                $display("FAIL soak_count n_stages=%0d: got %0d pulses expected %0d", 1 << d, soak_out_cnt[d], soak_in_cnt);
            end
        end

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
